// File: rtl/priority_decoder.sv
// priority_decoder
//   Takes a one-hot leftmost / rightmost set-bit word pair (as emitted by the
//   priority encoder) and rebuilds the contiguous mask between the two bits,
//   the binary index of each bit and the span length. Two-stage valid/ready
//   pipeline with a global stall; illegal pairs are flagged on error_o.
//
// Ports
//   clk_i          clock, rising edge
//   srst_i         synchronous reset, active low
//   data_left_i    one-hot leftmost set bit (or zero)
//   data_right_i   one-hot rightmost set bit (or zero)
//   data_val_i     input pair valid
//   data_ready_o   input pair can be accepted this cycle
//   range_mask_o   bits right_idx..left_idx set
//   left_idx_o     binary index of data_left_i
//   right_idx_o    binary index of data_right_i
//   count_o        number of set bits in range_mask_o
//   error_o        input pair was illegal
//   data_val_o     output bundle valid
//   data_ready_i   downstream accepts the output bundle
module priority_decoder #(
  parameter  int unsigned WIDTH = 16,
  localparam int unsigned IDX_W = $clog2(WIDTH),
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic [WIDTH-1:0] data_left_i,
  input  logic [WIDTH-1:0] data_right_i,
  input  logic             data_val_i,
  output logic             data_ready_o,
  output logic [WIDTH-1:0] range_mask_o,
  output logic [IDX_W-1:0] left_idx_o,
  output logic [IDX_W-1:0] right_idx_o,
  output logic [CNT_W-1:0] count_o,
  output logic             error_o,
  output logic             data_val_o,
  input  logic             data_ready_i
);

  function automatic logic is_onehot(input logic [WIDTH-1:0] w);
    return (w != '0) && ((w & (w - WIDTH'(1))) == '0);
  endfunction

  // OR of the indices of all set bits; exact for a one-hot word.
  function automatic logic [IDX_W-1:0] onehot_to_bin(input logic [WIDTH-1:0] w);
    logic [IDX_W-1:0] b;
    b = '0;
    for (int unsigned k = 0; k < WIDTH; k++) begin
      if (w[k]) b = b | IDX_W'(k);
    end
    return b;
  endfunction

  logic en;
  logic xfer;

  assign en           = !data_val_o || data_ready_i;
  assign data_ready_o = en && srst_i;
  assign xfer         = data_val_i && data_ready_o;

  // Stage 1 combinational legality and index extraction
  logic             left_oh, right_oh;
  logic             both_zero;
  logic [IDX_W-1:0] left_bin, right_bin;
  logic             pair_err;
  logic             pair_span;

  always_comb begin
    left_oh   = is_onehot(data_left_i);
    right_oh  = is_onehot(data_right_i);
    both_zero = (data_left_i == '0) && (data_right_i == '0);
    left_bin  = onehot_to_bin(data_left_i);
    right_bin = onehot_to_bin(data_right_i);
    pair_span = left_oh && right_oh && (left_bin >= right_bin);
    pair_err  = !both_zero && !pair_span;
  end

  logic             s1_valid;
  logic             s1_err;
  logic             s1_span;
  logic [IDX_W-1:0] s1_left_idx;
  logic [IDX_W-1:0] s1_right_idx;

  always_ff @(posedge clk_i) begin
    if (!srst_i) begin
      s1_valid     <= 1'b0;
      s1_err       <= 1'b0;
      s1_span      <= 1'b0;
      s1_left_idx  <= '0;
      s1_right_idx <= '0;
    end else if (en) begin
      s1_valid     <= xfer;
      s1_err       <= pair_err;
      s1_span      <= pair_span;
      // Indices are reported only for a legal, non-empty pair.
      s1_left_idx  <= pair_span ? left_bin  : '0;
      s1_right_idx <= pair_span ? right_bin : '0;
    end
  end

  // Stage 2 combinational mask / count
  logic [WIDTH-1:0] mask_nxt;
  logic [CNT_W-1:0] count_nxt;

  always_comb begin
    mask_nxt = '0;
    for (int unsigned k = 0; k < WIDTH; k++) begin
      mask_nxt[k] = s1_span && (IDX_W'(k) >= s1_right_idx) && (IDX_W'(k) <= s1_left_idx);
    end
    // Widened to CNT_W so a full-width span (WIDTH) does not wrap.
    count_nxt = s1_span ? (CNT_W'(s1_left_idx) - CNT_W'(s1_right_idx) + CNT_W'(1)) : '0;
  end

  always_ff @(posedge clk_i) begin
    if (!srst_i) begin
      data_val_o   <= 1'b0;
      range_mask_o <= '0;
      left_idx_o   <= '0;
      right_idx_o  <= '0;
      count_o      <= '0;
      error_o      <= 1'b0;
    end else if (en) begin
      data_val_o   <= s1_valid;
      range_mask_o <= mask_nxt;
      left_idx_o   <= s1_left_idx;
      right_idx_o  <= s1_right_idx;
      count_o      <= count_nxt;
      error_o      <= s1_err;
    end
  end

endmodule
